exc_commit_ctrl: RTL and testbench
==================================

Name: exc_commit_ctrl

Overview:
Parametrised exception-commit controller with built-in CP0 for the 5-stage MIPS core. It sits at the commit point after MEM. Each cycle it takes one committing instruction, prioritises its exception vector against pending interrupts, and updates BadVAddr/Count/Compare/Status/Cause/EPC. It drives a registered one-cycle pipeline flush with a redirect PC. Compared with the single-shot commit logic, it adds an N-source priority encoder, double-flop interrupt synchronisers, a Count/Compare timer interrupt and an explicit handler-state FSM.

Parameters:
N_EXC, 7, number of synchronous exception sources; bit 0 is highest priority
N_HWINT, 6, hardware interrupt lines, mapped to Cause.IP[7:2]
TIMER_EN, 1, 1 = Count/Compare timer present and ORed into IP7
CNT_DIV, 2, core cycles per Count increment; power of two, ≥1
EXC_VEC, 32'hBFC00380, general exception entry PC

Ports:
clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
ext_int  in  N_HWINT  asynchronous hardware interrupt lines
cm_valid  in  1  a real instruction is committing this cycle
cm_ex  in  N_EXC  exception flags of the committing instruction
cm_excode  in  5*N_EXC  ExcCode per source, packed, source i at [5i+4:5i]
cm_pc  in  32  PC of the committing instruction
cm_bd  in  1  committing instruction is in a delay slot
cm_badvaddr  in  32  faulting address for AdEL/AdES
cm_eret  in  1  committing instruction is ERET
cp0_wen  in  1  MTC0 write
cp0_addr  in  8  {rd[4:0], sel[2:0]}
cp0_wdata  in  32  MTC0 data
cp0_rdata  out  32  combinational read of cp0_addr
flush  out  1  registered one-cycle pipeline flush
flush_pc  out  32  redirect target, valid while flush=1
epc  out  32  EPC register
status  out  32  Status register
cause  out  32  Cause register
int_pending  out  1  an enabled interrupt is pending (to the IF hazard unit)

Behaviour:
- Reset values:
  - flush=0, flush_pc=0, EPC=0, BadVAddr=0, Count=0, Compare=0, divider=0.
  - Status=32'h0040_0000 (BEV=1, IE=0, EXL=0, IM=0).
  - Cause=0, timer_ip=0, synchronisers=0.
  - FSM=RUN.
- Interrupt path:
  - ext_int passes through a 2-flop synchroniser, giving 2 cycles latency to Cause.IP[7:2].
  - IP7 = sync[5] | (TIMER_EN & timer_ip).
  - IP[1:0] are software-writable through Cause.
  - int_pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Timer:
  - Count increments once per CNT_DIV cycles and wraps from 32'hFFFFFFFF to 0.
  - timer_ip is set the cycle Count==Compare and held.
  - Writing Compare clears timer_ip.
  - A Count write reloads Count and resets the divider.
- Exception selection, evaluated only when cm_valid=1 and FSM=RUN:
  - If int_pending=1, take an interrupt with ExcCode 0. Interrupts beat all synchronous sources.
  - Otherwise take the lowest-index set bit i of cm_ex, with ExcCode cm_excode[i].
  - AdEL/AdES (codes 4, 5) also latch BadVAddr=cm_badvaddr.
- Taking an exception, single cycle:
  - EPC = cm_bd ? cm_pc-4 : cm_pc.
  - Cause.BD = cm_bd, Cause.ExcCode = selected code, Status.EXL=1.
  - Next cycle flush=1 and flush_pc=EXC_VEC. FSM RUN→FLUSH→HANDLER.
- FSM:
  - RUN: normal operation.
  - FLUSH: one cycle with flush asserted; the commit input is ignored; goes to HANDLER.
  - HANDLER: EXL=1, no new exceptions or interrupts accepted.
    - cm_valid & cm_eret clears EXL and moves to RET.
    - cm_valid & |cm_ex while in HANDLER (nested) raises no flush and leaves EPC untouched; ExcCode is updated.
  - RET: one cycle with flush=1 and flush_pc=EPC; goes to RUN.
  - ERET committed in RUN (EXL=0) still produces RET with flush_pc=EPC.
- Simultaneous events:
  - Exception plus cp0_wen in the same cycle: the exception wins and the write is dropped.
  - ERET plus exception flag: the exception wins.
  - Compare write in the same cycle as a Count==Compare match: the clear wins.
  - ERET in the same cycle as a Status write: the EXL clear wins and other Status fields take wdata.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - Count, Compare and EPC: full width.
  - BadVAddr is read-only.
  - Reads of unimplemented addresses return 0.
- Reset asserted mid-FLUSH or mid-RET: everything returns to reset values immediately and flush drops asynchronously.

Decomposition:
- Shared package cp0_pkg holds:
  - CP0 address constants (BADVADDR=8'h40, COUNT=8'h48, COMPARE=8'h58, STATUS=8'h60, CAUSE=8'h68, EPC=8'h70).
  - ExcCode constants (INT, AdEL, AdES, Sys, Bp, RI, Ov).
  - Status/Cause bit positions.
  - FSM state encoding.
- One natural sub-module: cp0_timer (Count, divider, Compare, timer_ip, with its write ports).

Test Plan:
- Reset then idle: status=32'h00400000 and flush=0. With CNT_DIV=2, Count reads 5 after 10 cycles.
- Delay-slot syscall (cm_pc=32'h1004, cm_bd=1, cm_ex bit for Sys=8) → next cycle flush=1, flush_pc=32'hBFC00380. EPC=32'h1000, Cause=32'h8000_0020, EXL=1.
- Interrupt vs. synchronous exception:
  - Setup: IE=1, IM[2]=1, ext_int[0] pulsed high; after 2 cycles commit an Ov instruction.
  - Response: ExcCode=0 (interrupt wins) and Cause.IP2=1.
- Timer:
  - Setup: write Compare=3, let Count reach 3.
  - Response: IP7=1, and int_pending=1 when IM7 and IE are set.
  - Follow-up: write Compare=100 → IP7=0.
- AdEL with cm_badvaddr=32'h0000_0003 → BadVAddr=3. Then ERET in HANDLER → flush_pc=EPC and EXL=0 one cycle later.
- Second exception during HANDLER produces no flush and leaves EPC unchanged. An MTC0 Status write in the same cycle as an exception is ignored.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register addresses, ExcCodes, Status/Cause bit positions and
// the exception-commit FSM encoding shared by the commit controller and timer.
package cp0_pkg;
    localparam logic [7:0] A_BADVADDR = 8'h40;
    localparam logic [7:0] A_COUNT    = 8'h48;
    localparam logic [7:0] A_COMPARE  = 8'h58;
    localparam logic [7:0] A_STATUS   = 8'h60;
    localparam logic [7:0] A_CAUSE    = 8'h68;
    localparam logic [7:0] A_EPC      = 8'h70;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_IM  = 8;
    localparam int ST_BEV = 22;
    localparam int CA_EXC = 2;
    localparam int CA_IP  = 8;
    localparam int CA_BD  = 31;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HANDLER, S_RET} state_t;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer; Count advances once every CNT_DIV cycles and
// timer_ip latches on a Count==Compare match until Compare is rewritten.
module cp0_timer #(
    parameter int CNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_ip
);
    localparam int DW = CNT_DIV > 1 ? $clog2(CNT_DIV) : 1;

    logic [DW-1:0] div;
    logic          tick;

    assign tick = div == DW'(CNT_DIV - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            count    <= '0;
            compare  <= '0;
            timer_ip <= 1'b0;
        end else begin
            div      <= (count_wen | tick) ? '0 : div + 1'b1;
            count    <= count_wen ? wdata : count + 32'(tick);
            if (compare_wen) compare <= wdata;
            // a Compare write beats a match in the same cycle
            timer_ip <= ~compare_wen & (timer_ip | (count == compare));
        end
    end
endmodule

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: commit-point exception/interrupt arbitration with CP0
// (BadVAddr/Count/Compare/Status/Cause/EPC) and a registered flush/redirect.
module exc_commit_ctrl
    import cp0_pkg::*;
#(
    parameter int          N_EXC    = 7,
    parameter int          N_HWINT  = 6,
    parameter int          TIMER_EN = 1,
    parameter int          CNT_DIV  = 2,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_HWINT-1:0] ext_int,
    input  logic               cm_valid,
    input  logic [N_EXC-1:0]   cm_ex,
    input  logic [5*N_EXC-1:0] cm_excode,
    input  logic [31:0]        cm_pc,
    input  logic               cm_bd,
    input  logic [31:0]        cm_badvaddr,
    input  logic               cm_eret,
    input  logic               cp0_wen,
    input  logic [7:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    output logic               flush,
    output logic [31:0]        flush_pc,
    output logic [31:0]        epc,
    output logic [31:0]        status,
    output logic [31:0]        cause,
    output logic               int_pending
);
    state_t             state, state_n;
    logic [N_HWINT-1:0] sync1, sync2;
    logic [5:0]         hw;
    logic [7:0]         ip, im;
    logic [1:0]         ip_sw;
    logic               ie, exl, bd;
    logic [4:0]         code, sel;
    logic [31:0]        badvaddr, count, compare;
    logic               timer_ip;
    logic               run, take, nest, eret_do, wr;

    always_comb begin
        sel = '0;
        for (int i = N_EXC - 1; i >= 0; i--)
            if (cm_ex[i]) sel = cm_excode[5*i +: 5];
    end

    assign hw          = 6'(sync2);
    assign ip          = {hw[5] | (timer_ip & 1'(TIMER_EN)), hw[4:0], ip_sw};
    assign int_pending = ie & ~exl & |(ip & im);
    assign status      = (32'd1 << ST_BEV) | (32'(im) << ST_IM) | (32'(exl) << ST_EXL) | (32'(ie) << ST_IE);
    assign cause       = (32'(bd) << CA_BD) | (32'(ip) << CA_IP) | (32'(code) << CA_EXC);

    // interrupts are only taken by a real commit in RUN; HANDLER only logs nested codes
    assign run     = state == S_RUN;
    assign take    = run & cm_valid & (int_pending | |cm_ex);
    assign nest    = state == S_HANDLER & cm_valid & |cm_ex;
    assign eret_do = cm_valid & cm_eret & ~take & ~nest & (run | state == S_HANDLER);
    assign wr      = cp0_wen & ~take & ~nest;

    always_comb begin
        state_n  = state == S_FLUSH ? S_HANDLER :
                   state == S_RET   ? S_RUN     :
                   take             ? S_FLUSH   :
                   eret_do          ? S_RET     : state;
        flush    = state == S_FLUSH || state == S_RET;
        flush_pc = state == S_FLUSH ? EXC_VEC : state == S_RET ? epc : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RUN;
            sync1    <= '0;
            sync2    <= '0;
            epc      <= '0;
            badvaddr <= '0;
            bd       <= 1'b0;
            code     <= '0;
            ip_sw    <= '0;
            im       <= '0;
            ie       <= 1'b0;
            exl      <= 1'b0;
        end else begin
            state <= state_n;
            sync1 <= ext_int;
            sync2 <= sync1;
            if (take) begin
                epc <= cm_bd ? cm_pc - 32'd4 : cm_pc;
                bd  <= cm_bd;
                exl <= 1'b1;
                if (~int_pending & ((sel == EXC_ADEL) | (sel == EXC_ADES))) badvaddr <= cm_badvaddr;
            end
            if (take | nest) code <= (take & int_pending) ? EXC_INT : sel;
            if (wr && cp0_addr == A_EPC) epc <= cp0_wdata;
            if (wr && cp0_addr == A_CAUSE) ip_sw <= cp0_wdata[CA_IP +: 2];
            if (wr && cp0_addr == A_STATUS) begin
                im  <= cp0_wdata[ST_IM +: 8];
                exl <= cp0_wdata[ST_EXL];
                ie  <= cp0_wdata[ST_IE];
            end
            // ERET's EXL clear overrides a same-cycle Status write
            if (eret_do) exl <= 1'b0;
        end
    end

    cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .count_wen   (wr && cp0_addr == A_COUNT),
        .compare_wen (wr && cp0_addr == A_COMPARE),
        .wdata       (cp0_wdata),
        .count       (count),
        .compare     (compare),
        .timer_ip    (timer_ip)
    );

    assign cp0_rdata = cp0_addr == A_BADVADDR ? badvaddr :
                       cp0_addr == A_COUNT    ? count    :
                       cp0_addr == A_COMPARE  ? compare  :
                       cp0_addr == A_STATUS   ? status   :
                       cp0_addr == A_CAUSE    ? cause    :
                       cp0_addr == A_EPC      ? epc      : '0;
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: directed scenarios plus random traffic, every cycle
// compared against an architectural CP0/commit model.
module tb_exc_commit_ctrl;
    localparam int          N_EXC   = 7;
    localparam int          N_HWINT = 6;
    localparam int          CNT_DIV = 2;
    localparam logic [31:0] VEC     = 32'hBFC00380;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_HWINT-1:0] ext_int;
    logic               cm_valid, cm_bd, cm_eret, cp0_wen;
    logic [N_EXC-1:0]   cm_ex;
    logic [5*N_EXC-1:0] cm_excode;
    logic [31:0]        cm_pc, cm_badvaddr, cp0_wdata;
    logic [7:0]         cp0_addr;
    logic [31:0]        cp0_rdata, flush_pc, epc, status, cause;
    logic               flush, int_pending;

    always #5 clk = ~clk;

    exc_commit_ctrl #(
        .N_EXC(N_EXC), .N_HWINT(N_HWINT), .TIMER_EN(1), .CNT_DIV(CNT_DIV), .EXC_VEC(VEC)
    ) dut (
        .clk(clk), .reset(reset), .ext_int(ext_int), .cm_valid(cm_valid), .cm_ex(cm_ex),
        .cm_excode(cm_excode), .cm_pc(cm_pc), .cm_bd(cm_bd), .cm_badvaddr(cm_badvaddr),
        .cm_eret(cm_eret), .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .flush(flush), .flush_pc(flush_pc), .epc(epc),
        .status(status), .cause(cause), .int_pending(int_pending)
    );

    logic [4:0] codes [N_EXC] = '{5'd4, 5'd5, 5'd10, 5'd8, 5'd9, 5'd12, 5'd13};
    logic [7:0] addrs [8]     = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00, 8'h61};

    int checks = 0;
    int failures = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // architectural model: mode 0 run, 1 flush, 2 handler, 3 return
    int          m_mode, m_ticks;
    logic [31:0] m_epc, m_badv, m_base, m_cmp;
    logic [7:0]  m_im;
    logic [1:0]  m_sw;
    logic [4:0]  m_code;
    logic        m_ie, m_exl, m_bd, m_tip;
    logic [5:0]  m_hist[$];

    task automatic model_reset();
        m_mode = 0; m_ticks = 0; m_epc = 0; m_badv = 0; m_base = 0; m_cmp = 0;
        m_im = 0; m_sw = 0; m_code = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_tip = 0;
        m_hist = '{6'd0, 6'd0};
    endtask

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_ticks / CNT_DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        logic [5:0] h;
        h = m_hist[1];
        return {h[5] | m_tip, h[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic m_intp();
        return m_ie & ~m_exl & |(m_ip() & m_im);
    endfunction

    function automatic logic [31:0] m_rd(logic [7:0] a);
        case (a)
            8'h40:   return m_badv;
            8'h48:   return m_count();
            8'h58:   return m_cmp;
            8'h60:   return m_status();
            8'h68:   return m_cause();
            8'h70:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] cnt;
        logic [4:0]  s;
        logic        intp, take, nest, eret, wr, tip_n;
        int          first;
        cnt = m_count();
        intp = m_intp();
        first = -1;
        for (int i = 0; i < N_EXC; i++)
            if (cm_ex[i] && first < 0) first = i;
        s = first >= 0 ? codes[first] : 5'd0;
        take = m_mode == 0 && cm_valid && (intp || first >= 0);
        nest = m_mode == 2 && cm_valid && first >= 0;
        eret = cm_valid && cm_eret && !take && !nest && (m_mode == 0 || m_mode == 2);
        wr = cp0_wen && !take && !nest;
        tip_n = (wr && cp0_addr == 8'h58) ? 1'b0 : (m_tip | (cnt == m_cmp));
        if (take) begin
            m_epc = cm_bd ? cm_pc - 4 : cm_pc;
            m_bd = cm_bd;
            m_exl = 1;
            m_code = intp ? 5'd0 : s;
            if (!intp && (s == 4 || s == 5)) m_badv = cm_badvaddr;
        end
        if (nest) m_code = s;
        if (wr && cp0_addr == 8'h48) begin
            m_base = cp0_wdata;
            m_ticks = 0;
        end else m_ticks++;
        if (wr && cp0_addr == 8'h58) m_cmp = cp0_wdata;
        if (wr && cp0_addr == 8'h60) begin
            m_im = cp0_wdata[15:8];
            m_exl = cp0_wdata[1];
            m_ie = cp0_wdata[0];
        end
        if (wr && cp0_addr == 8'h68) m_sw = cp0_wdata[9:8];
        if (wr && cp0_addr == 8'h70) m_epc = cp0_wdata;
        if (eret) m_exl = 0;
        m_tip = tip_n;
        m_mode = m_mode == 1 ? 2 : m_mode == 3 ? 0 : take ? 1 : eret ? 3 : m_mode;
        m_hist.push_front(ext_int);
        void'(m_hist.pop_back());
    endtask

    task automatic cyc();
        #1;
        check("flush", flush, m_mode == 1 || m_mode == 3);
        check("flush_pc", flush_pc, m_mode == 1 ? VEC : m_mode == 3 ? m_epc : 32'h0);
        check("epc", epc, m_epc);
        check("status", status, m_status());
        check("cause", cause, m_cause());
        check("int_pending", int_pending, m_intp());
        check("rdata", cp0_rdata, m_rd(cp0_addr));
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cm_valid = 0; cm_ex = 0; cm_eret = 0; cp0_wen = 0;
    endtask

    task automatic mtc0(logic [7:0] a, logic [31:0] d);
        cp0_wen = 1; cp0_addr = a; cp0_wdata = d;
        cyc();
        idle();
    endtask

    initial begin
        reset = 1; ext_int = 0; cm_pc = 0; cm_bd = 0; cm_badvaddr = 0;
        cp0_addr = 0; cp0_wdata = 0;
        idle();
        for (int i = 0; i < N_EXC; i++) cm_excode[5*i +: 5] = codes[i];
        repeat (3) @(negedge clk);
        reset = 0;
        model_reset();
        #1;
        check("reset_status", status, 32'h0040_0000);
        check("reset_flush", flush, 0);

        cp0_addr = 8'h48;
        repeat (10) cyc();
        check("count_after_10", cp0_rdata, 32'd5);

        mtc0(8'h58, 32'hFFFF_0000);

        cm_valid = 1; cm_pc = 32'h1004; cm_bd = 1; cm_ex = 7'b0001000;
        cyc();
        idle();
        check("sys_flush", flush, 1);
        check("sys_flush_pc", flush_pc, VEC);
        check("sys_epc", epc, 32'h1000);
        check("sys_cause", cause, 32'h8000_0020);
        check("sys_status", status, 32'h0040_0002);
        cyc();
        check("handler_flush", flush, 0);
        cm_valid = 1; cm_eret = 1;
        cyc();
        idle();
        check("eret_flush", flush, 1);
        check("eret_pc", flush_pc, 32'h1000);
        check("eret_status", status, 32'h0040_0000);
        cyc();

        mtc0(8'h60, 32'h0000_0401);
        ext_int = 6'b000001;
        cyc();
        cyc();
        check("irq_pending", int_pending, 1);
        cm_valid = 1; cm_ex = 7'b0100000; cm_bd = 0; cm_pc = 32'h2468;
        cyc();
        idle();
        ext_int = 0;
        check("irq_code", cause[6:2], 0);
        check("irq_ip2", cause[10], 1);
        check("irq_epc", epc, 32'h2468);
        repeat (3) cyc();
        cm_valid = 1; cm_eret = 1;
        cyc();
        idle();
        cyc();

        mtc0(8'h60, 32'h0000_8001);
        mtc0(8'h48, 32'h0);
        mtc0(8'h58, 32'd3);
        repeat (10) cyc();
        check("timer_ip7", cause[15], 1);
        check("timer_pending", int_pending, 1);
        mtc0(8'h58, 32'd100);
        check("timer_clear", cause[15], 0);
        mtc0(8'h60, 32'h0);

        cm_valid = 1; cm_ex = 7'b0000001; cm_badvaddr = 32'h3; cm_pc = 32'h2000; cm_bd = 0;
        cp0_wen = 1; cp0_addr = 8'h60; cp0_wdata = 32'h0000_FF03;
        cyc();
        idle();
        cp0_addr = 8'h40;
        #1;
        check("adel_badv", cp0_rdata, 32'h3);
        check("adel_status_drop", status, 32'h0040_0002);
        cyc();
        cyc();
        cm_valid = 1; cm_ex = 7'b0100000; cm_pc = 32'h3000;
        cyc();
        idle();
        check("nest_flush", flush, 0);
        check("nest_epc", epc, 32'h2000);
        check("nest_code", cause[6:2], 12);
        cm_valid = 1; cm_eret = 1;
        cyc();
        idle();
        check("adel_ret_pc", flush_pc, 32'h2000);
        check("adel_ret_exl", status[1], 0);
        cyc();

        cm_valid = 1; cm_ex = 7'b0001000;
        cyc();
        idle();
        check("pre_reset_flush", flush, 1);
        #2 reset = 1;
        #1;
        check("async_flush", flush, 0);
        check("async_status", status, 32'h0040_0000);
        check("async_epc", epc, 0);
        @(negedge clk);
        reset = 0;
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            cm_valid = $urandom_range(0, 1) == 1;
            cm_ex = $urandom_range(0, 3) == 0 ? 7'($urandom) : 7'h0;
            cm_eret = $urandom_range(0, 5) == 0;
            cm_bd = $urandom_range(0, 1) == 1;
            cm_pc = $urandom & 32'hFFFF_FFFC;
            cm_badvaddr = $urandom;
            cp0_wen = $urandom_range(0, 3) == 0;
            cp0_addr = addrs[$urandom_range(0, 7)];
            cp0_wdata = $urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(0, 20));
            if ($urandom_range(0, 9) == 0) ext_int = 6'($urandom);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
